mem_check_monitor: RTL and testbench
====================================

# mem_check_monitor

Result monitor sitting directly downstream of each DDR memory checker instance. It consumes the checker's fail/done flags and expected/detected read-data observation buses, and tracks test state, mismatch count, run time and timeout. It also latches a first-failure data snapshot and drives a single status LED. The outputs are intended for the VIO debug core and board pins.

## Interface
- DATA_W, 256, width of expected/detected data buses
- CNT_W, 16, width of saturating mismatch counter
- TIME_W, 32, width of run-cycle counter; all-ones = timeout
- BLINK_DIV, 24, width of free-running LED divider

- axi_clk  in  1  sole clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  level; begins monitoring (driven by PLL lock)
- clr  in  1  synchronous clear, highest priority (VIO)
- fail_i  in  1  checker fail flag, level; rising edges are events
- done_i  in  1  checker done flag, level
- rdata_exp_i  in  DATA_W  checker expected data
- rdata_det_i  in  DATA_W  checker detected data
- state_o  out  2  monitor state encoding
- err_cnt  out  CNT_W  count of fail_i rising edges, saturating
- run_cycles  out  TIME_W  cycles spent in RUN, saturating
- timeout  out  1  sticky; RUN reached TIME_W all-ones without done
- first_exp  out  DATA_W  rdata_exp_i at first fail edge
- first_det  out  DATA_W  rdata_det_i at first fail edge
- led_status  out  1  status LED

## Operation
- Edge detect: fail_q <= fail_i; fail_edge = fail_i & ~fail_q. Same scheme for done_i (done_edge).
- States are IDLE=0, RUN=1, PASS=2, FAIL=3.
- IDLE -> RUN when start=1.
- RUN -> FAIL on fail_edge. This takes precedence when done_edge occurs in the same cycle.
- RUN -> FAIL when run_cycles == all-ones; timeout <= 1.
- RUN -> PASS on done_edge with err_cnt == 0 and no fail_edge.
- PASS -> FAIL on fail_edge. A late error is never masked.
- FAIL is terminal until clr or reset.
- start deasserting while in RUN/PASS/FAIL is ignored.
- err_cnt increments on every fail_edge outside IDLE and saturates at 2^CNT_W-1.
- run_cycles increments each cycle in RUN only and holds in PASS/FAIL.
- Snapshot: on the first fail_edge (err_cnt==0), first_exp/first_det are loaded from the inputs of that same cycle. Later edges do not overwrite them.
- clr from any state forces the following: state IDLE; err_cnt, run_cycles, timeout, snapshots and fail_q/done_q cleared. clr beats all events in the same cycle.
- LED: a BLINK_DIV-bit divider runs freely.
  - IDLE: led = 0.
  - RUN: led = div[BLINK_DIV-1] (slow blink).
  - PASS: led = 1.
  - FAIL: led = div[BLINK_DIV-4] (fast blink).

## Timing
- Reset values: state_o=0 (IDLE), err_cnt=0, run_cycles=0, timeout=0, first_exp=0, first_det=0, led_status=0. Divider and edge flops are also 0.
- All outputs are registered.
- fail_i rise at cycle N: fail_edge is seen at N (fail_q from N-1). err_cnt, state_o, first_* and the state-based LED select update at the N+1 edge.
- start sampled at N: state_o=RUN from N+1, and run_cycles=1 at N+2.
- Timeout: on the cycle run_cycles reads all-ones, state_o=FAIL and timeout=1 from the next cycle.
- fail_i held high produces one event only. It must drop and rise again to count again.
- A reset assertion mid-run clears everything asynchronously. There is no recovery state.

## Configuration
- MEM_MON_SNAPSHOT_EN defined: first_exp/first_det registers are built as described.
- Not defined: first_exp/first_det are driven constant 0, rdata_*_i are unused, and no snapshot flops are synthesised. All other behaviour is identical.

## Structure
- Package mem_mon_pkg holds:
  - the state encoding constants (MON_IDLE, MON_RUN, MON_PASS, MON_FAIL);
  - a 2-bit state typedef;
  - the fast-blink tap offset (3).
- One sub-module, mon_led_blink, contains the free-running divider and the state-to-LED mux. Inputs are axi_clk, rstn and state; output is led.

## Test plan
All scenarios use test parameters DATA_W=8, CNT_W=4, TIME_W=6, BLINK_DIV=6.
- Clean run: start=1, then done_i rises 20 cycles later. Required: state_o=2, err_cnt=0, run_cycles=20, led_status=1 steady.
- First-fail snapshot: during RUN, fail_i pulses with exp=8'hA5, det=8'h25, then a second pulse with exp=8'h11. Required: state_o=3, err_cnt=2, first_exp=8'hA5, first_det=8'h25.
- Simultaneous events: fail_i and done_i rise in the same cycle. Required: state_o=3, err_cnt=1.
- Saturation and late error:
  - 20 fail pulses -> err_cnt=15.
  - PASS followed by a fail pulse -> FAIL.
  - fail_i held high for 10 cycles -> err_cnt increments by exactly 1.
- Timeout: start with no done. Required: after 63 RUN cycles, state_o=3, timeout=1, run_cycles=63, LED toggles every 4 cycles.
- Clear and reset:
  - clr asserted in FAIL together with a fail edge -> IDLE, all counters 0.
  - rstn dropped mid-RUN -> all outputs 0 asynchronously.
  - Build without MEM_MON_SNAPSHOT_EN -> first_* remain 0 after a fail.

Source files
------------

// File: rtl/mem_mon_pkg.sv
// Shared types and constants for the memory-checker result monitor.
package mem_mon_pkg;

    // Monitor state encoding, visible to VIO as state_o
    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_RUN  = 2'd1,
        MON_PASS = 2'd2,
        MON_FAIL = 2'd3
    } mon_state_t;

    // Fast blink taps this many bits below the divider MSB
    localparam int unsigned FAST_TAP_OFS = 3;

endpackage : mem_mon_pkg

// File: rtl/mon_led_blink.sv
// Free-running divider and state-to-LED mux for the monitor status LED.
module mon_led_blink
    import mem_mon_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 24
) (
    input  logic       axi_clk,
    input  logic       rstn,
    input  mon_state_t state,
    output logic       led
);

    localparam int unsigned SLOW_TAP = BLINK_DIV - 1;
    localparam int unsigned FAST_TAP = BLINK_DIV - 1 - FAST_TAP_OFS;

    logic [BLINK_DIV-1:0] div_q;
    logic                 led_d;

    // Divider runs regardless of state so blink phase never stalls
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + BLINK_DIV'(1);
        end
    end

    // Select the LED pattern for the state being entered
    always_comb begin
        led_d = 1'b0;
        case (state)
            MON_IDLE: led_d = 1'b0;
            MON_RUN:  led_d = div_q[SLOW_TAP];
            MON_PASS: led_d = 1'b1;
            MON_FAIL: led_d = div_q[FAST_TAP];
            default:  led_d = 1'b0;
        endcase
    end

    // Registered LED drive
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            led <= 1'b0;
        end else begin
            led <= led_d;
        end
    end

endmodule : mon_led_blink

// File: rtl/mem_check_monitor.sv
// Result monitor downstream of a DDR memory checker: test state, mismatch
// count, run time, timeout, first-failure snapshot and status LED.
// Define MEM_MON_SNAPSHOT_EN to build the first_exp/first_det snapshot flops.
module mem_check_monitor
    import mem_mon_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIME_W    = 32,
    parameter int unsigned BLINK_DIV = 24
) (
    input  logic              axi_clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              clr,
    input  logic              fail_i,
    input  logic              done_i,
    input  logic [DATA_W-1:0] rdata_exp_i,
    input  logic [DATA_W-1:0] rdata_det_i,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [TIME_W-1:0] run_cycles,
    output logic              timeout,
    output logic [DATA_W-1:0] first_exp,
    output logic [DATA_W-1:0] first_det,
    output logic              led_status
);

    mon_state_t state_q;
    mon_state_t state_d;
    logic       fail_q;
    logic       done_q;
    logic       fail_edge_c;
    logic       done_edge_c;
    logic       count_fail_c;
    logic       run_max_c;
    logic       err_max_c;
    logic       timeout_set_c;

    assign fail_edge_c  = fail_i & ~fail_q;
    assign done_edge_c  = done_i & ~done_q;
    assign count_fail_c = fail_edge_c && (state_q != MON_IDLE);
    assign run_max_c    = (run_cycles == {TIME_W{1'b1}});
    assign err_max_c    = (err_cnt == {CNT_W{1'b1}});
    assign state_o      = state_q;

    // Edge-detect history; cleared by clr so a held flag re-arms
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            fail_q <= 1'b0;
            done_q <= 1'b0;
        end else if (clr) begin
            fail_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fail_q <= fail_i;
            done_q <= done_i;
        end
    end

    // State register
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= MON_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clr first, then fail edge, timeout, clean done
    always_comb begin
        state_d       = state_q;
        timeout_set_c = 1'b0;
        if (clr) begin
            state_d = MON_IDLE;
        end else begin
            case (state_q)
                MON_IDLE: begin
                    if (start) state_d = MON_RUN;
                end
                MON_RUN: begin
                    if (fail_edge_c) begin
                        state_d = MON_FAIL;
                    end else if (run_max_c) begin
                        state_d       = MON_FAIL;
                        timeout_set_c = 1'b1;
                    end else if (done_edge_c && (err_cnt == '0)) begin
                        state_d = MON_PASS;
                    end
                end
                MON_PASS: begin
                    if (fail_edge_c) state_d = MON_FAIL;
                end
                MON_FAIL: state_d = MON_FAIL;
                default:  state_d = MON_IDLE;
            endcase
        end
    end

    // Saturating mismatch count, run-cycle count and sticky timeout
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt    <= '0;
            run_cycles <= '0;
            timeout    <= 1'b0;
        end else if (clr) begin
            err_cnt    <= '0;
            run_cycles <= '0;
            timeout    <= 1'b0;
        end else begin
            if (count_fail_c && !err_max_c) err_cnt <= err_cnt + CNT_W'(1);
            if ((state_q == MON_RUN) && !run_max_c) run_cycles <= run_cycles + TIME_W'(1);
            if (timeout_set_c) timeout <= 1'b1;
        end
    end

`ifdef MEM_MON_SNAPSHOT_EN
    logic snap_c;
    assign snap_c = count_fail_c && (err_cnt == '0);

    // Capture the data observed with the first counted fail edge
    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            first_exp <= '0;
            first_det <= '0;
        end else if (clr) begin
            first_exp <= '0;
            first_det <= '0;
        end else if (snap_c) begin
            first_exp <= rdata_exp_i;
            first_det <= rdata_det_i;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^{rdata_exp_i, rdata_det_i};
    assign first_exp    = '0;
    assign first_det    = '0;
`endif

    // LED follows the state being entered so it switches with state_o
    mon_led_blink #(
        .BLINK_DIV (BLINK_DIV)
    ) u_led (
        .axi_clk (axi_clk),
        .rstn    (rstn),
        .state   (state_d),
        .led     (led_status)
    );

endmodule : mem_check_monitor

// File: tb/tb_mem_check_monitor.sv
// Directed bench for mem_check_monitor with small parameters.
module tb_mem_check_monitor;

    logic       axi_clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       clr;
    logic       fail_i;
    logic       done_i;
    logic [7:0] rdata_exp_i;
    logic [7:0] rdata_det_i;
    logic [1:0] state_o;
    logic [3:0] err_cnt;
    logic [5:0] run_cycles;
    logic       timeout;
    logic [7:0] first_exp;
    logic [7:0] first_det;
    logic       led_status;

    int errors = 0;
    int checks = 0;

`ifdef MEM_MON_SNAPSHOT_EN
    localparam logic [7:0] EXP_FIRST_EXP = 8'hA5;
    localparam logic [7:0] EXP_FIRST_DET = 8'h25;
`else
    localparam logic [7:0] EXP_FIRST_EXP = 8'h00;
    localparam logic [7:0] EXP_FIRST_DET = 8'h00;
`endif

    mem_check_monitor #(
        .DATA_W    (8),
        .CNT_W     (4),
        .TIME_W    (6),
        .BLINK_DIV (6)
    ) dut (
        .axi_clk     (axi_clk),
        .rstn        (rstn),
        .start       (start),
        .clr         (clr),
        .fail_i      (fail_i),
        .done_i      (done_i),
        .rdata_exp_i (rdata_exp_i),
        .rdata_det_i (rdata_det_i),
        .state_o     (state_o),
        .err_cnt     (err_cnt),
        .run_cycles  (run_cycles),
        .timeout     (timeout),
        .first_exp   (first_exp),
        .first_det   (first_det),
        .led_status  (led_status)
    );

    always #5 axi_clk = ~axi_clk;

    // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; clr = 1'b0; fail_i = 1'b0; done_i = 1'b0;
        rdata_exp_i = 8'h00; rdata_det_i = 8'h00;
        cyc(2);
        rstn = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b1; clr = 1'b0; fail_i = 1'b1; done_i = 1'b1;
        rdata_exp_i = 8'hFF; rdata_det_i = 8'hFF;
        cyc(3);
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
        checks++; if (run_cycles !== 6'd0) begin errors++; $display("FAIL reset_run got=%0d exp=0", run_cycles); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
        checks++; if (first_exp !== 8'h00 || first_det !== 8'h00) begin errors++; $display("FAIL reset_snap got=%h/%h exp=00/00", first_exp, first_det); end
        checks++; if (led_status !== 1'b0) begin errors++; $display("FAIL reset_led got=%0b exp=0", led_status); end
    endtask

    task automatic test_clean_run();
        do_reset();
        start = 1'b1;
        cyc(1);
        checks++; if (state_o !== 2'd1 || run_cycles !== 6'd0) begin errors++; $display("FAIL clean_enter got=%0d/%0d exp=1/0", state_o, run_cycles); end
        cyc(1);
        checks++; if (run_cycles !== 6'd1) begin errors++; $display("FAIL clean_run1 got=%0d exp=1", run_cycles); end
        cyc(18);
        done_i = 1'b1;
        cyc(1);
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL clean_state got=%0d exp=2", state_o); end
        checks++; if (err_cnt !== 4'd0) begin errors++; $display("FAIL clean_err got=%0d exp=0", err_cnt); end
        checks++; if (run_cycles !== 6'd20) begin errors++; $display("FAIL clean_run got=%0d exp=20", run_cycles); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (led_status !== 1'b1) begin errors++; $display("FAIL clean_led[%0d] got=%0b exp=1", i, led_status); end
            cyc(1);
        end
        checks++; if (run_cycles !== 6'd20 || state_o !== 2'd2) begin errors++; $display("FAIL clean_hold got=%0d/%0d exp=20/2", run_cycles, state_o); end
        done_i = 1'b0;
    endtask

    task automatic test_first_fail();
        do_reset();
        start = 1'b1;
        cyc(4);
        fail_i = 1'b1; rdata_exp_i = 8'hA5; rdata_det_i = 8'h25;
        cyc(1);
        checks++; if (state_o !== 2'd3 || err_cnt !== 4'd1) begin errors++; $display("FAIL snap_first got=%0d/%0d exp=3/1", state_o, err_cnt); end
        fail_i = 1'b0; rdata_exp_i = 8'h00; rdata_det_i = 8'h00;
        cyc(2);
        fail_i = 1'b1; rdata_exp_i = 8'h11; rdata_det_i = 8'h77;
        cyc(1);
        fail_i = 1'b0;
        cyc(1);
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL snap_state got=%0d exp=3", state_o); end
        checks++; if (err_cnt !== 4'd2) begin errors++; $display("FAIL snap_err got=%0d exp=2", err_cnt); end
        checks++; if (first_exp !== EXP_FIRST_EXP) begin errors++; $display("FAIL snap_exp got=%h exp=%h", first_exp, EXP_FIRST_EXP); end
        checks++; if (first_det !== EXP_FIRST_DET) begin errors++; $display("FAIL snap_det got=%h exp=%h", first_det, EXP_FIRST_DET); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        start = 1'b1;
        cyc(3);
        fail_i = 1'b1; done_i = 1'b1;
        cyc(1);
        fail_i = 1'b0; done_i = 1'b0;
        cyc(1);
        checks++; if (state_o !== 2'd3 || err_cnt !== 4'd1) begin errors++; $display("FAIL simul got=%0d/%0d exp=3/1", state_o, err_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        start = 1'b1;
        cyc(2);
        for (int i = 0; i < 20; i++) begin
            fail_i = 1'b1; cyc(1);
            fail_i = 1'b0; cyc(1);
        end
        checks++; if (err_cnt !== 4'd15) begin errors++; $display("FAIL sat_err got=%0d exp=15", err_cnt); end
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL sat_state got=%0d exp=3", state_o); end
    endtask

    task automatic test_late_error();
        do_reset();
        start = 1'b1;
        cyc(2);
        done_i = 1'b1;
        cyc(1);
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL late_pass got=%0d exp=2", state_o); end
        cyc(2);
        fail_i = 1'b1;
        cyc(1);
        checks++; if (state_o !== 2'd3 || err_cnt !== 4'd1) begin errors++; $display("FAIL late_fail got=%0d/%0d exp=3/1", state_o, err_cnt); end
        cyc(9);
        checks++; if (err_cnt !== 4'd1) begin errors++; $display("FAIL late_held got=%0d exp=1", err_cnt); end
        fail_i = 1'b0;
        cyc(1);
        fail_i = 1'b1;
        cyc(1);
        checks++; if (err_cnt !== 4'd2) begin errors++; $display("FAIL late_rearm got=%0d exp=2", err_cnt); end
        fail_i = 1'b0; done_i = 1'b0;
    endtask

    task automatic test_timeout();
        logic s [16];
        logic ok;
        do_reset();
        start = 1'b1;
        cyc(1);
        cyc(63);
        checks++; if (state_o !== 2'd1 || timeout !== 1'b0 || run_cycles !== 6'd63) begin errors++; $display("FAIL tmo_edge got=%0d/%0b/%0d exp=1/0/63", state_o, timeout, run_cycles); end
        cyc(1);
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL tmo_state got=%0d exp=3", state_o); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag got=%0b exp=1", timeout); end
        checks++; if (run_cycles !== 6'd63) begin errors++; $display("FAIL tmo_run got=%0d exp=63", run_cycles); end
        for (int i = 0; i < 16; i++) begin
            s[i] = led_status;
            cyc(1);
        end
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (s[i+4] === s[i] || (i < 8 && s[i+8] !== s[i])) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_led_period got=irregular exp=toggle_every_4"); end
        checks++; if (run_cycles !== 6'd63 || timeout !== 1'b1) begin errors++; $display("FAIL tmo_hold got=%0d/%0b exp=63/1", run_cycles, timeout); end
    endtask

    task automatic test_clear();
        do_reset();
        start = 1'b1;
        cyc(65);
        fail_i = 1'b1; rdata_exp_i = 8'h3C; rdata_det_i = 8'hC3;
        cyc(1);
        fail_i = 1'b0;
        cyc(1);
        checks++; if (state_o !== 2'd3 || err_cnt !== 4'd1 || timeout !== 1'b1) begin errors++; $display("FAIL clr_pre got=%0d/%0d/%0b exp=3/1/1", state_o, err_cnt, timeout); end
        clr = 1'b1; fail_i = 1'b1; start = 1'b0;
        cyc(1);
        clr = 1'b0; fail_i = 1'b0;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL clr_state got=%0d exp=0", state_o); end
        checks++; if (err_cnt !== 4'd0 || run_cycles !== 6'd0 || timeout !== 1'b0) begin errors++; $display("FAIL clr_cnt got=%0d/%0d/%0b exp=0/0/0", err_cnt, run_cycles, timeout); end
        checks++; if (first_exp !== 8'h00 || first_det !== 8'h00) begin errors++; $display("FAIL clr_snap got=%h/%h exp=00/00", first_exp, first_det); end
        checks++; if (led_status !== 1'b0) begin errors++; $display("FAIL clr_led got=%0b exp=0", led_status); end
        start = 1'b1;
        cyc(2);
        checks++; if (state_o !== 2'd1 || run_cycles !== 6'd1) begin errors++; $display("FAIL clr_restart got=%0d/%0d exp=1/1", state_o, run_cycles); end
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1'b1;
        cyc(10);
        done_i = 1'b1;
        cyc(1);
        done_i = 1'b0;
        fail_i = 1'b1; rdata_exp_i = 8'h5A; rdata_det_i = 8'h99;
        cyc(1);
        fail_i = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        checks++; if (state_o !== 2'd0 || err_cnt !== 4'd0 || run_cycles !== 6'd0) begin errors++; $display("FAIL arst_cnt got=%0d/%0d/%0d exp=0/0/0", state_o, err_cnt, run_cycles); end
        checks++; if (timeout !== 1'b0 || led_status !== 1'b0 || first_exp !== 8'h00 || first_det !== 8'h00) begin errors++; $display("FAIL arst_out got=%0b/%0b/%h/%h exp=0/0/00/00", timeout, led_status, first_exp, first_det); end
        cyc(1);
        rstn = 1'b1;
        start = 1'b0;
        cyc(1);
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_first_fail();
        test_simultaneous();
        test_saturation();
        test_late_error();
        test_timeout();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_check_monitor
